// File: rtl/io_input_unit.sv
// io_input_unit: switch/button input stage with debounce, press latch and IO read mux
module io_input_unit #(
   parameter int DB_CYCLES = 200000,
   parameter int CNT_W     = 18
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] switch_raw,
   input  logic        button_raw,
   input  logic        ioRead,
   input  logic        SwitchCtrl,
   input  logic        ButtonCtrl,
   output logic [15:0] io_rdata,
   output logic        btn_level
);
   typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   logic [15:0]      sw_q1, sw_q2;
   logic             bt_q1, bt_q2;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             level_q;
   logic             pending_q, pending_d;
   logic [7:0]       press_cnt_q, press_cnt_d;
   logic             press_ev, rd_btn;
   // two-flop synchronisers for the asynchronous switches and button
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_q1 <= '0;
         sw_q2 <= '0;
         bt_q1 <= 1'b0;
         bt_q2 <= 1'b0;
      end else begin
         sw_q1 <= switch_raw;
         sw_q2 <= sw_q1;
         bt_q1 <= button_raw;
         bt_q2 <= bt_q1;
      end
   end
   // debounce FSM: a level change is accepted only after DB_CYCLES stable cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         case (state_q)
            RELEASED: if (bt_q2) begin
               state_q <= PRESS_WAIT;
               cnt_q   <= CNT_W'(1);
            end
            PRESS_WAIT: if (!bt_q2) begin
               state_q <= RELEASED;
               cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
               state_q <= PRESSED;
               cnt_q   <= '0;
               level_q <= 1'b1;
            end else cnt_q <= cnt_q + CNT_W'(1);
            PRESSED: if (!bt_q2) begin
               state_q <= RELEASE_WAIT;
               cnt_q   <= CNT_W'(1);
            end
            RELEASE_WAIT: if (bt_q2) begin
               state_q <= PRESSED;
               cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
               state_q <= RELEASED;
               cnt_q   <= '0;
               level_q <= 1'b0;
            end else cnt_q <= cnt_q + CNT_W'(1);
            default: begin
               state_q <= RELEASED;
               cnt_q   <= '0;
               level_q <= 1'b0;
            end
         endcase
      end
   end
   // press event fires on the edge that moves the FSM into PRESSED; a coincident read loses to it
   always_comb begin
      press_ev    = (state_q == PRESS_WAIT) && bt_q2 && (cnt_q == CNT_LAST);
      rd_btn      = ioRead && ButtonCtrl;
      pending_d   = press_ev || (pending_q && !rd_btn);
      press_cnt_d = press_cnt_q + 8'(press_ev);
      io_rdata    = rd_btn ? {press_cnt_q, 6'b0, level_q, pending_q} :
                    (ioRead && SwitchCtrl) ? sw_q2 : 16'h0000;
      btn_level   = level_q;
   end
   // pending flag and wrapping press counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q   <= 1'b0;
         press_cnt_q <= '0;
      end else begin
         pending_q   <= pending_d;
         press_cnt_q <= press_cnt_d;
      end
   end
endmodule

// File: tb/tb_io_input_unit.sv
// tb_io_input_unit: scoreboard bench for io_input_unit with DB_CYCLES=4
module tb_io_input_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] switch_raw = '0;
   logic        button_raw = 1'b0;
   logic        ioRead = 1'b0;
   logic        SwitchCtrl = 1'b0;
   logic        ButtonCtrl = 1'b0;
   logic [15:0] io_rdata;
   logic        btn_level;
   int          checks = 0;
   int          failures = 0;
   logic [15:0] sb_q[$];

   io_input_unit #(.DB_CYCLES(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .switch_raw(switch_raw), .button_raw(button_raw),
      .ioRead(ioRead), .SwitchCtrl(SwitchCtrl), .ButtonCtrl(ButtonCtrl),
      .io_rdata(io_rdata), .btn_level(btn_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v);
      sb_q.push_back(v);
   endtask

   task automatic rd(input string tag, input logic io, input logic b, input logic s, input logic hold);
      logic [15:0] e;
      ioRead = io;
      ButtonCtrl = b;
      SwitchCtrl = s;
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty, got %h", tag, io_rdata);
      end else begin
         e = sb_q.pop_front();
         chk(tag, io_rdata, e);
      end
      if (hold) tick(1);
      ioRead = 1'b0;
      ButtonCtrl = 1'b0;
      SwitchCtrl = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      // reset with switches high and button held
      switch_raw = 16'hFFFF;
      button_raw = 1'b1;
      tick(2);
      rst_n = 1'b1;
      chk("rst_level", {15'b0, btn_level}, 16'h0000);
      push(16'h0000); rd("rst_sw", 1, 0, 1, 0);
      push(16'h0000); rd("rst_btn", 1, 1, 0, 0);
      tick(1);
      push(16'h0000); rd("sw_lat1", 1, 0, 1, 0);
      tick(1);
      push(16'hFFFF); rd("sw_lat2", 1, 0, 1, 0);
      tick(4);
      chk("held_level", {15'b0, btn_level}, 16'h0001);
      push(16'h0103); rd("held_press", 1, 1, 0, 1);
      push(16'h0102); rd("held_clear", 1, 1, 0, 0);
      button_raw = 1'b0;
      tick(8);
      chk("rel_level", {15'b0, btn_level}, 16'h0000);
      push(16'h0100); rd("rel_btn", 1, 1, 0, 0);
      // switch path
      switch_raw = 16'hA5C3;
      tick(1);
      push(16'hFFFF); rd("sw_a5_e1", 1, 0, 1, 0);
      tick(1);
      push(16'hA5C3); rd("sw_a5_e2", 1, 0, 1, 0);
      switch_raw = 16'h0001;
      tick(1);
      push(16'hA5C3); rd("sw_01_e1", 1, 0, 1, 0);
      tick(1);
      push(16'h0001); rd("sw_01_e2", 1, 0, 1, 0);
      push(16'h0000); rd("sw_noread", 0, 0, 1, 0);
      push(16'h0000); rd("no_cs", 1, 0, 0, 0);
      // bounce rejection
      foreach (pat[i]) begin
         button_raw = pat[i];
         tick(1);
      end
      button_raw = 1'b0;
      tick(4);
      chk("bounce_level", {15'b0, btn_level}, 16'h0000);
      push(16'h0100); rd("bounce_btn", 1, 1, 0, 0);
      button_raw = 1'b1;
      tick(5);
      chk("steady_e4_level", {15'b0, btn_level}, 16'h0000);
      push(16'h0100); rd("steady_e4_btn", 1, 1, 0, 0);
      tick(1);
      chk("steady_level", {15'b0, btn_level}, 16'h0001);
      push(16'h0203); rd("rtc_read", 1, 1, 0, 1);
      push(16'h0202); rd("rtc_after", 1, 1, 0, 0);
      // read coinciding with the press-event edge
      button_raw = 1'b0;
      tick(8);
      button_raw = 1'b1;
      tick(5);
      push(16'h0200); rd("align_read", 1, 1, 0, 1);
      push(16'h0303); rd("align_after", 1, 1, 0, 0);
      chk("align_level", {15'b0, btn_level}, 16'h0001);
      button_raw = 1'b0;
      tick(8);
      // counter wrap
      for (int k = 0; k < 252; k++) begin
         button_raw = 1'b1;
         tick(8);
         button_raw = 1'b0;
         tick(8);
      end
      push(16'hFF01); rd("cnt_255", 1, 1, 0, 0);
      button_raw = 1'b1;
      tick(8);
      button_raw = 1'b0;
      tick(8);
      push(16'h0001); rd("cnt_wrap", 1, 1, 0, 0);
      // chip-select priority
      push(16'h0001); rd("prio", 1, 1, 1, 0);
      // reset in the middle of PRESS_WAIT
      button_raw = 1'b1;
      tick(4);
      push(16'h0001); rd("pw_btn", 1, 1, 0, 0);
      rst_n = 1'b0;
      button_raw = 1'b0;
      tick(1);
      rst_n = 1'b1;
      chk("midrst_level", {15'b0, btn_level}, 16'h0000);
      push(16'h0000); rd("midrst_btn", 1, 1, 0, 0);
      push(16'h0000); rd("midrst_sw", 1, 0, 1, 0);
      tick(8);
      chk("midrst_level2", {15'b0, btn_level}, 16'h0000);
      push(16'h0000); rd("midrst_noev", 1, 1, 0, 0);
      chk("sb_empty", 16'(sb_q.size()), 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
